// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, response and data-memory bundle
// for the load/store unit (slave = LSU, master = core + memory).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [1:0]  mem_store_size;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_is_store, req_funct3,
    input  req_addr, req_wdata, rsp_ready,
    input  mem_read_data,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_fault, mem_read_en, mem_write_en,
    output mem_addr, mem_store_size, mem_write_data
  );

  modport master (
    output req_valid, req_is_store, req_funct3,
    output req_addr, req_wdata, rsp_ready,
    output mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_fault, mem_read_en, mem_write_en,
    input  mem_addr, mem_store_size, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store front end, one request in flight.
// Optional macro LSU_BOUNDS_CHECK_EN faults accesses past MEM_SIZE.
module load_store_unit #(
  parameter int unsigned MEM_SIZE = 512
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  f3_q;
  logic        fault_q;
  logic [31:0] rdata_q;
  logic [31:0] ld_fmt;
  logic        accept;
  logic        bad_f3;
  logic        misal;
  logic        oob;
  logic        fault;
  logic        go;

  // decode funct3 legality and natural alignment
  always_comb begin
    bad_f3 = 1'b0;
    misal  = 1'b0;
    unique case (bus.req_funct3)
      3'b000, 3'b100: misal = 1'b0;
      3'b001, 3'b101: misal = bus.req_addr[0];
      3'b010:         misal = |bus.req_addr[1:0];
      default:        bad_f3 = 1'b1;
    endcase
    if (bus.req_is_store && bus.req_funct3[2])
      bad_f3 = 1'b1;
  end

`ifdef LSU_BOUNDS_CHECK_EN
  logic [2:0]  nbytes;
  logic [32:0] end_addr;

  // 33-bit end address so a wrapping access still trips
  assign nbytes   = 3'd1 << bus.req_funct3[1:0];
  assign end_addr = {1'b0, bus.req_addr}
                  + {30'd0, nbytes};
  assign oob      = end_addr > 33'(MEM_SIZE);
`else
  assign oob = 1'b0;
`endif

  assign accept = (state == IDLE)
               && bus.req_valid && !rst;
  assign fault  = bad_f3 | misal | oob;
  assign go     = accept && !fault;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next state, handshakes and memory strobes
  always_comb begin
    state_nxt          = state;
    bus.req_ready      = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.mem_read_en    = 1'b0;
    bus.mem_write_en   = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_store_size = '0;
    bus.mem_write_data = '0;
    unique case (state)
      IDLE: begin
        bus.req_ready = !rst;
        if (accept) begin
          if (go && !bus.req_is_store)
            state_nxt = LOAD_WAIT;
          else
            state_nxt = RESP;
        end
        if (go) begin
          bus.mem_read_en    = !bus.req_is_store;
          bus.mem_write_en   = bus.req_is_store;
          bus.mem_addr       = bus.req_addr;
          bus.mem_store_size = bus.req_funct3[1:0];
          if (bus.req_is_store)
            bus.mem_write_data = bus.req_wdata;
        end
      end
      LOAD_WAIT: state_nxt = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // select and extend the returned load bytes
  always_comb begin
    ld_fmt = bus.mem_read_data;
    unique case (1'b1)
      f3_q == 3'b000:
        ld_fmt = {{24{bus.mem_read_data[7]}},
                  bus.mem_read_data[7:0]};
      f3_q == 3'b100:
        ld_fmt = {24'd0, bus.mem_read_data[7:0]};
      f3_q == 3'b001:
        ld_fmt = {{16{bus.mem_read_data[15]}},
                  bus.mem_read_data[15:0]};
      f3_q == 3'b101:
        ld_fmt = {16'd0, bus.mem_read_data[15:0]};
      default:
        ld_fmt = bus.mem_read_data;
    endcase
  end

  // capture request attributes and response payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q    <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      f3_q    <= bus.req_funct3;
      fault_q <= fault;
      rdata_q <= '0;
    end else if (state == LOAD_WAIT) begin
      rdata_q <= ld_fmt;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_fault = fault_q;

endmodule
